// File: rtl/axis_decomp_framer_if.sv
// rtl/axis_decomp_framer_if.sv - input stream bundle for axis_decomp_framer
//
// Signals: tdata/tkeep/tvalid/tlast driven by the source, tready by the sink.
// modport master : stream source
// modport slave  : stream sink (axis_decomp_framer)
interface axis_decomp_framer_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_decomp_framer.sv
// rtl/axis_decomp_framer.sv - packet framer: header/payload classification and bitmap window cursor
//
// Ports:
//   axis_aclk, axis_areset      clock, synchronous active-high reset
//   s_axis (slave modport)      input stream tdata/tkeep/tvalid/tlast/tready
//   is_header, is_payload_1     combinational classification of the presented beat
//   need_decomp                 current packet is compressed (latched on beat 0)
//   beat_cnt                    beats accepted in the current packet (saturating)
//   bitmap, bitmap_valid        BITMAP_W-bit window slice at cursor, MSB-first
//   adv_valid, adv_bits         cursor advance request (0..DATA_W bits)
//   cursor                      bit position within the older window slot
//   pkt_done                    one-cycle end-of-packet pulse
//
// Build option: define DECOMP_MAGIC_CHECK_EN to compare the beat-0 marker
// against MAGIC; without it every packet is treated as compressed.
module axis_decomp_framer #(
  parameter int          DATA_W    = 256,
  parameter int          HDR_BEATS = 4,
  parameter int          BITMAP_W  = 16,
  parameter logic [15:0] MAGIC     = 16'hDEC0,
  parameter int          CNT_W     = 16
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  axis_decomp_framer_if.slave       s_axis,
  output logic                      is_header,
  output logic                      is_payload_1,
  output logic                      need_decomp,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic [BITMAP_W-1:0]       bitmap,
  output logic                      bitmap_valid,
  input  logic                      adv_valid,
  input  logic [$clog2(DATA_W):0]   adv_bits,
  output logic [$clog2(DATA_W)-1:0] cursor,
  output logic                      pkt_done
);
  localparam int                CW         = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  HDR_CNT    = CNT_W'(HDR_BEATS);
  localparam logic [CNT_W-1:0]  HDR_LAST   = CNT_W'(HDR_BEATS - 1);
  localparam logic [CW+1:0]     DW_EXT     = (CW+2)'(DATA_W);
  localparam int                SHIFT_BASE = 2*DATA_W - BITMAP_W;

  typedef enum logic [1:0] {IDLE, HDR, PAY, BYPASS} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] older_q, older_d, newer_q, newer_d;
  logic              older_vld_q, older_vld_d, newer_vld_q, newer_vld_d;
  logic              older_last_q, older_last_d, newer_last_q, newer_last_d;
  logic              last_loaded_q, last_loaded_d;
  logic              need_q, need_d;
  logic              pkt_done_q, pkt_done_d;
  logic [CW-1:0]     cursor_q, cursor_d;

  logic              tready, accept, adv_fire, wrap, pay_end, hdr_end, need_new;
  logic [CW+1:0]     cur_next;
  logic [2*DATA_W-1:0] window;

`ifdef DECOMP_MAGIC_CHECK_EN
  assign need_new = (s_axis.tdata[DATA_W-1 -: 16] == MAGIC);
`else
  logic unused_magic;
  assign need_new     = 1'b1;
  assign unused_magic = ^MAGIC;
`endif

  // tkeep carries no meaning for this block
  logic unused_tkeep;
  assign unused_tkeep = ^s_axis.tkeep;

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid && tready;
  assign adv_fire      = adv_valid && bitmap_valid;
  assign cur_next      = {2'b00, cursor_q} + {1'b0, adv_bits};
  assign wrap          = adv_fire && (cur_next >= DW_EXT);
  assign pay_end       = wrap && older_last_q;
  // tlast outside PAY ends the packet without touching the window
  assign hdr_end       = accept && s_axis.tlast && (state_q != PAY);

  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      older_q       <= '0;
      newer_q       <= '0;
      older_vld_q   <= 1'b0;
      newer_vld_q   <= 1'b0;
      older_last_q  <= 1'b0;
      newer_last_q  <= 1'b0;
      last_loaded_q <= 1'b0;
      need_q        <= 1'b0;
      pkt_done_q    <= 1'b0;
      cursor_q      <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      older_q       <= older_d;
      newer_q       <= newer_d;
      older_vld_q   <= older_vld_d;
      newer_vld_q   <= newer_vld_d;
      older_last_q  <= older_last_d;
      newer_last_q  <= newer_last_d;
      last_loaded_q <= last_loaded_d;
      need_q        <= need_d;
      pkt_done_q    <= pkt_done_d;
      cursor_q      <= cursor_d;
    end
  end

  // Datapath: counter, window slots, cursor
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    older_d       = older_q;
    newer_d       = newer_q;
    older_vld_d   = older_vld_q;
    newer_vld_d   = newer_vld_q;
    older_last_d  = older_last_q;
    newer_last_d  = newer_last_q;
    last_loaded_d = last_loaded_q;
    need_d        = need_q;
    pkt_done_d    = 1'b0;
    cursor_d      = cursor_q;

    if (accept) begin
      if (s_axis.tlast)            beat_cnt_d = '0;
      else if (beat_cnt_q != '1)   beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (state_q == IDLE)         need_d = need_new;
      // tready in PAY guarantees a free slot here and no concurrent advance
      if (state_q == PAY) begin
        if (!older_vld_q) begin
          older_d      = s_axis.tdata;
          older_vld_d  = 1'b1;
          older_last_d = s_axis.tlast;
        end else begin
          newer_d      = s_axis.tdata;
          newer_vld_d  = 1'b1;
          newer_last_d = s_axis.tlast;
        end
        last_loaded_d = last_loaded_q | s_axis.tlast;
      end
    end

    if (adv_fire) begin
      if (!wrap) begin
        cursor_d = CW'(cur_next);
      end else if (older_last_q) begin
        older_vld_d   = 1'b0;
        newer_vld_d   = 1'b0;
        older_last_d  = 1'b0;
        newer_last_d  = 1'b0;
        last_loaded_d = 1'b0;
        cursor_d      = '0;
        need_d        = 1'b0;
        pkt_done_d    = 1'b1;
      end else begin
        older_d      = newer_q;
        older_vld_d  = newer_vld_q;
        older_last_d = newer_last_q;
        newer_vld_d  = 1'b0;
        newer_last_d = 1'b0;
        cursor_d     = CW'(cur_next - DW_EXT);
      end
    end

    if (hdr_end) begin
      need_d     = 1'b0;
      pkt_done_d = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HDR: begin
        if (accept) begin
          if (s_axis.tlast)               state_d = IDLE;
          else if (beat_cnt_q >= HDR_LAST) state_d = need_d ? PAY : BYPASS;
          else                            state_d = HDR;
        end
      end
      PAY:     if (pay_end) state_d = IDLE;
      BYPASS:  if (accept && s_axis.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    tready       = (state_q != PAY) || (!(older_vld_q && newer_vld_q) && !last_loaded_q);
    bitmap_valid = (state_q == PAY) && older_vld_q && (newer_vld_q || older_last_q);
    is_header    = s_axis.tvalid && (beat_cnt_q < HDR_CNT);
    is_payload_1 = s_axis.tvalid && (state_q == PAY) && (beat_cnt_q == HDR_CNT);
    window       = {older_q, newer_vld_q ? newer_q : {DATA_W{1'b0}}};
    // window[2*DATA_W-1-cursor -: BITMAP_W] expressed as a right shift
    bitmap       = BITMAP_W'(window >> (SHIFT_BASE - int'(cursor_q)));
    need_decomp  = need_q;
    beat_cnt     = beat_cnt_q;
    cursor       = cursor_q;
    pkt_done     = pkt_done_q;
  end
endmodule

// File: doc/axis_decomp_framer.md
AXIS_DECOMP_FRAMER -- requirements
Module: axis_decomp_framer

Interface
REQ-001 SHALL have parameter DATA_W, 256, stream data width in bits (multiple of 8, ≥ 2*BITMAP_W).
REQ-002 SHALL have parameter HDR_BEATS, 4, number of header beats per packet (≥1).
REQ-003 SHALL have parameter BITMAP_W, 16, width of the extracted bitmap window.
REQ-004 SHALL have parameter MAGIC, 16'hDEC0, compression marker in beat 0 bits [DATA_W-1 -: 16].
REQ-005 SHALL have parameter CNT_W, 16, beat counter width.
REQ-006 axis_aclk  in  1  sole clock, all logic rising-edge.
REQ-007 axis_areset  in  1  synchronous, active-high reset.
REQ-008 s_axis_tdata/tkeep/tvalid/tlast  in  DATA_W/DATA_W/8/1/1  input stream; tkeep is not interpreted.
REQ-009 s_axis_tready  out  1  input backpressure.
REQ-010 is_header / is_payload_1  out  1/1  classify the beat currently presented.
REQ-011 need_decomp  out  1  current packet carries MAGIC.
REQ-012 beat_cnt  out  CNT_W  beats accepted in current packet.
REQ-013 bitmap / bitmap_valid  out  BITMAP_W/1  window slice at cursor.
REQ-014 adv_valid / adv_bits  in  1/$clog2(DATA_W)+1  cursor advance request, adv_bits ≤ DATA_W.
REQ-015 cursor  out  $clog2(DATA_W)  bit position within the older window beat; pkt_done  out  1  one-cycle end-of-packet pulse.

Function
REQ-016 Beat accepted iff s_axis_tvalid && s_axis_tready; beat_cnt increments per accept, saturates at 2^CNT_W-1, clears on the cycle after the accept carrying tlast.
REQ-017 FSM states IDLE, HDR, PAY, BYPASS; IDLE→HDR on first accept; HDR→PAY after HDR_BEATS accepts if need_decomp, else →BYPASS; any→IDLE at packet end.
REQ-018 s_axis_tready SHALL be 1 in IDLE/HDR/BYPASS, and in PAY only while fewer than 2 window slots are filled and tlast has not yet been loaded.
REQ-019 is_header = 1 iff s_axis_tvalid and beat index < HDR_BEATS; is_payload_1 = 1 iff s_axis_tvalid, state PAY, and beat index == HDR_BEATS; both combinational.
REQ-020 need_decomp is registered on beat-0 accept, held until packet end.
REQ-021 Window = {older, newer}, 2*DATA_W bits; bitmap = window[2*DATA_W-1-cursor -: BITMAP_W], MSB-first; an absent newer slot reads as zeros.
REQ-022 bitmap_valid = 1 in PAY when both slots are filled, or the older slot is filled and holds the tlast beat.
REQ-023 adv_valid is ignored while bitmap_valid = 0; otherwise next = cursor + adv_bits, computed $clog2(DATA_W)+2 bits wide.
REQ-024 If next < DATA_W: cursor ← next; else cursor ← next-DATA_W, older ← newer, newer slot emptied (one slot freed, tready rises next cycle).
REQ-025 Wrap while older slot holds the tlast beat SHALL pulse pkt_done, clear cursor/slots, enter IDLE.
REQ-026 tlast accepted in HDR or BYPASS SHALL pulse pkt_done the following cycle and enter IDLE; PAY never entered.
REQ-027 Payload beats in BYPASS SHALL not load the window; bitmap_valid stays 0.

Reset
REQ-028 On axis_areset: state IDLE, beat_cnt 0, cursor 0, slots empty, need_decomp 0, pkt_done 0, bitmap_valid 0; s_axis_tready = 1 from the first cycle after reset.
REQ-029 Reset mid-packet SHALL discard the packet; the next accepted beat is treated as beat 0.

Configuration
REQ-030 Macro DECOMP_MAGIC_CHECK_EN: defined → need_decomp = (beat-0 marker == MAGIC); undefined → need_decomp = 1 for every packet, MAGIC unused.

Verification
REQ-031 6-beat packet, beat0 marker DEC0, no adv → is_header beats 0-3, is_payload_1 beat 4, tready drops after beat 5, bitmap_valid = 1.
REQ-032 Same packet, adv_bits = 200 then 100 → cursor 200, then 44 with slot shift; tready high one cycle later.
REQ-033 Marker 1234 with macro defined → BYPASS, need_decomp 0, tready held 1, pkt_done one cycle after tlast.
REQ-034 5-beat packet (tlast on beat 4, one payload) → bitmap lower half zero-filled; adv 256 → pkt_done, IDLE, cursor 0.
REQ-035 axis_areset asserted at beat 2 → all outputs at reset values; next beat gives is_header = 1, beat_cnt 0→1.
REQ-036 3-beat packet with tlast on beat 2 → pkt_done, no PAY entry, back-to-back packet accepted with no bubble.
